// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared fighter state encoding and default constants
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    ATTACK = 3'd2,
    DEFEND = 3'd3,
    HURT   = 3'd4,
    DEAD   = 3'd5
  } state_t;

  localparam logic [9:0] X_INIT_DEF     = 10'd100;
  localparam logic [6:0] HEALTH_MAX_DEF = 7'd100;

  function automatic logic [6:0] health_after_hit(input logic [6:0] health,
                                                  input logic [6:0] dmg);
    return (health > dmg) ? health - dmg : 7'd0;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame strobe synchroniser and rising-edge tick generator
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_frame_clk,
  output logic o_tick
);

  logic r_sync1, r_sync2, r_prev, r_tick;

  // Registered edge detect puts the tick three Clk after the frame edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_frame_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_sync2 & ~r_prev;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/fighter_action_fsm.sv
// rtl/fighter_action_fsm.sv - frame-locked fighter action controller
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter logic [9:0] X_INIT      = X_INIT_DEF,
  parameter logic [9:0] X_MIN       = 10'd0,
  parameter logic [9:0] X_MAX       = 10'd560,
  parameter logic [9:0] STEP        = 10'd2,
  parameter logic [3:0] ATK_WINDUP  = 4'd4,
  parameter logic [3:0] ATK_ACTIVE  = 4'd3,
  parameter logic [3:0] ATK_RECOVER = 4'd6,
  parameter logic [3:0] HURT_FRAMES = 4'd12,
  parameter logic [6:0] DMG         = 7'd10,
  parameter logic [6:0] BLOCK_DMG   = 7'd2,
  parameter logic [6:0] HEALTH_MAX  = HEALTH_MAX_DEF,
  parameter logic [2:0] ANIM_DIV    = 3'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_clk,
  input  logic       i_move_l,
  input  logic       i_move_r,
  input  logic       i_attack,
  input  logic       i_defense,
  input  logic       i_hit_in,
  output logic [9:0] o_pos_x,
  output logic       o_facing_r,
  output logic [2:0] o_anim_state,
  output logic [1:0] o_anim_frame,
  output logic       o_hit_window,
  output logic [6:0] o_health,
  output logic       o_dead
);

  localparam logic [3:0] ATK_LAST = ATK_WINDUP + ATK_ACTIVE + ATK_RECOVER - 4'd1;
  localparam logic [3:0] HIT_LAST = ATK_WINDUP + ATK_ACTIVE - 4'd1;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_phase, w_phase_nxt;
  logic [3:0] r_stun, w_stun_nxt;
  logic [9:0] r_pos_x, w_pos_nxt;
  logic       r_facing_r, w_facing_nxt;
  logic [6:0] r_health, w_health_nxt, w_health_hit;
  logic [2:0] r_anim_cnt, w_anim_cnt_nxt;
  logic [1:0] r_anim_frame, w_anim_frame_nxt;
  logic       r_hit_window, w_hit_window_nxt;
  logic       r_dead;
  logic       r_pending_hit;
  logic       w_tick, w_hit;

  frame_tick_gen u_tick (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame_clk (i_frame_clk),
    .o_tick      (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_stun_nxt   = r_stun;
    w_pos_nxt    = r_pos_x;
    w_facing_nxt = r_facing_r;
    w_health_nxt = r_health;
    w_hit        = r_pending_hit | i_hit_in;
    w_health_hit = health_after_hit(r_health, (r_state == DEFEND) ? BLOCK_DMG : DMG);

    case (r_state)
      IDLE, WALK, DEFEND: begin
        if (w_hit) begin
          w_health_nxt = w_health_hit;
          w_state_nxt  = (w_health_hit == 7'd0) ? DEAD : HURT;
          w_stun_nxt   = HURT_FRAMES;
        end else if (i_attack) begin
          w_state_nxt = ATTACK;
          w_phase_nxt = 4'd0;
        end else if (i_defense) begin
          w_state_nxt = DEFEND;
        end else if (i_move_l ^ i_move_r) begin
          w_state_nxt  = WALK;
          w_facing_nxt = i_move_r;
          if (i_move_r)
            w_pos_nxt = (r_pos_x > X_MAX - STEP) ? X_MAX : r_pos_x + STEP;
          else
            w_pos_nxt = (r_pos_x < X_MIN + STEP) ? X_MIN : r_pos_x - STEP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ATTACK: begin
        if (w_hit) begin
          w_health_nxt = w_health_hit;
          w_state_nxt  = (w_health_hit == 7'd0) ? DEAD : HURT;
          w_stun_nxt   = HURT_FRAMES;
        end else if (r_phase == ATK_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_phase_nxt = r_phase + 4'd1;
        end
      end
      HURT: begin
        // Repeat hits cost health but the stun keeps counting down.
        if (w_hit) w_health_nxt = w_health_hit;
        if (w_hit && (w_health_hit == 7'd0)) begin
          w_state_nxt = DEAD;
        end else if (r_stun <= 4'd1) begin
          w_state_nxt = IDLE;
          w_stun_nxt  = 4'd0;
        end else begin
          w_stun_nxt = r_stun - 4'd1;
        end
      end
      DEAD:    w_state_nxt = DEAD;
      default: w_state_nxt = IDLE;
    endcase

    w_anim_cnt_nxt   = r_anim_cnt;
    w_anim_frame_nxt = r_anim_frame;
    if (w_state_nxt != r_state) begin
      w_anim_cnt_nxt   = 3'd0;
      w_anim_frame_nxt = 2'd0;
    end else if (r_anim_cnt == ANIM_DIV - 3'd1) begin
      w_anim_cnt_nxt   = 3'd0;
      w_anim_frame_nxt = r_anim_frame + 2'd1;
    end else begin
      w_anim_cnt_nxt = r_anim_cnt + 3'd1;
    end

    w_hit_window_nxt = (w_state_nxt == ATTACK) && (w_phase_nxt >= ATK_WINDUP) &&
                       (w_phase_nxt <= HIT_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_phase       <= 4'd0;
      r_stun        <= 4'd0;
      r_pos_x       <= X_INIT;
      r_facing_r    <= 1'b1;
      r_health      <= HEALTH_MAX;
      r_anim_cnt    <= 3'd0;
      r_anim_frame  <= 2'd0;
      r_hit_window  <= 1'b0;
      r_dead        <= 1'b0;
      r_pending_hit <= 1'b0;
    end else if (w_tick) begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_stun        <= w_stun_nxt;
      r_pos_x       <= w_pos_nxt;
      r_facing_r    <= w_facing_nxt;
      r_health      <= w_health_nxt;
      r_anim_cnt    <= w_anim_cnt_nxt;
      r_anim_frame  <= w_anim_frame_nxt;
      r_hit_window  <= w_hit_window_nxt;
      r_dead        <= (w_state_nxt == DEAD);
      r_pending_hit <= 1'b0;
    end else if (i_hit_in) begin
      r_pending_hit <= 1'b1;
    end
  end

  assign o_pos_x      = r_pos_x;
  assign o_facing_r   = r_facing_r;
  assign o_anim_state = r_state;
  assign o_anim_frame = r_anim_frame;
  assign o_hit_window = r_hit_window;
  assign o_health     = r_health;
  assign o_dead       = r_dead;

endmodule
